// File: rtl/bank_access_arbiter.sv
// Two-requester round-robin arbiter in front of an 8-word storage bank.
// After reset the bank is cleared by a sweep, one word per cycle, with busy high.
// Each granted access takes three cycles: IDLE latches the winner,
// ACCESS touches the bank, and RESP pulses ack.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req[1:0]        per-requester access request
//   we[1:0]         per-requester write enable (1 = write, 0 = read)
//   addr0, addr1    requester word addresses
//   wdata0, wdata1  requester write data
//   ack[1:0]        one-cycle completion pulse to the winner
//   rdata           read data, valid while ack is high
//   wsel[7:0]       one-hot bank word select
//   busy            high while the post-reset clear sweep runs
module bank_access_arbiter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [2:0]        addr0,
  input  logic [2:0]        addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        wsel,
  output logic              busy
);

  typedef enum logic [1:0] {StInit, StIdle, StAccess, StResp} state_e;

  state_e            r_state;
  logic [2:0]        r_idx;
  logic              r_ptr;    // last winner
  logic              r_win;
  logic              r_we;
  logic [2:0]        r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_bank [8];

  logic              w_win;
  logic [7:0]        w_wsel;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_bank_we;
  logic [DATA_W-1:0] w_bank_wdata;

  // With both requests up, the requester that did not win last time gets the bank.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_ptr;
      default: w_win = 1'b0;
    endcase
  end

  // Word select is forced low during reset so no bank word is touched then.
  always_comb begin
    w_wsel = 8'h00;
    case (r_state)
      StInit:   w_wsel = 8'h01 << r_idx;
      StAccess: w_wsel = 8'h01 << r_addr;
      default:  w_wsel = 8'h00;
    endcase
    if (rst) begin
      w_wsel = 8'h00;
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < 8; k++) begin
      w_rd_word = w_rd_word | (r_bank[k] & {DATA_W{w_wsel[k]}});
    end
  end

  assign w_bank_we    = (r_state == StInit) || ((r_state == StAccess) && r_we);
  assign w_bank_wdata = (r_state == StInit) ? '0 : r_wdata;

  // The bank is cleared by the sweep rather than by reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (w_bank_we && w_wsel[k]) begin
        r_bank[k] <= w_bank_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StInit;
      r_idx   <= 3'd0;
      r_ptr   <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 3'd0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        StInit: begin
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            r_state <= StIdle;
          end
        end
        StIdle: begin
          if (req != 2'b00) begin
            r_win   <= w_win;
            r_addr  <= w_win ? addr1 : addr0;
            r_we    <= we[w_win];
            r_wdata <= w_win ? wdata1 : wdata0;
            r_state <= StAccess;
          end
        end
        StAccess: begin
          if (!r_we) begin
            r_rdata <= w_rd_word;
          end
          r_state <= StResp;
        end
        StResp: begin
          r_ptr   <= r_win;
          r_state <= StIdle;
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign ack   = (r_state == StResp) ? (r_win ? 2'b10 : 2'b01) : 2'b00;
  assign rdata = r_rdata;
  assign wsel  = w_wsel;
  assign busy  = (r_state == StInit);

endmodule
